post_proc_ctrl: RTL and testbench
=================================

Name: post_proc_ctrl

Overview:
- Frame-level controller that sequences the filter post-processing stage.
- Holds the kernel/mode/threshold configuration in double-buffered (pending/active) registers. Active config is swapped only at frame start, so it never changes mid-frame.
- Counts pixels into the filter pipeline and out of the post-processing stage, then signals frame completion.
- Sits between the host/config interface and the convolution + post_proc datapath; drives that datapath's kernel_address, select_mode and threshold inputs.

Parameters:
- IMG_WIDTH, 640, pixels per line.
- IMG_HEIGHT, 480, lines per frame.
- DRAIN_TIMEOUT, 1024, max cycles allowed in DRAIN before a forced DONE.
- FRAME_PIXELS, IMG_WIDTH*IMG_HEIGHT, derived (localparam); CNT_W = $clog2(FRAME_PIXELS+1).

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  async active-low reset.
- i_cfg_valid  in  1  config write strobe.
- i_cfg_kernel  in  3  kernel address to load.
- i_cfg_select_mode  in  1  select mode to load.
- i_cfg_threshold  in  1  threshold enable to load.
- i_start  in  1  start one frame (honoured in IDLE only).
- i_continuous  in  1  auto-restart after DONE.
- i_abort  in  1  abort current frame.
- i_pix_valid  in  1  pixel entering filter pipeline.
- i_out_valid  in  1  post-processing output data_ready.
- o_kernel_address  out  3  active kernel to datapath.
- o_select_mode  out  1  active select mode.
- o_threshold  out  1  active threshold enable.
- o_cfg_ack  out  1  1-cycle pulse, cycle after a cfg write.
- o_busy  out  1  high in RUN/DRAIN/DONE.
- o_frame_done  out  1  1-cycle pulse in DONE.
- o_in_count  out  CNT_W  pixels accepted this frame.
- o_out_count  out  CNT_W  outputs seen this frame.
- o_overrun  out  1  sticky error flag.
- o_timeout  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0, pending cfg 0, active cfg 0, state IDLE. Reset mid-frame behaves the same; no partial state survives.
- Config write:
  - i_cfg_valid in any state latches into pending; o_cfg_ack pulses the next cycle.
  - Writes in RUN/DRAIN/DONE do not touch active; they take effect at the next frame start.
- IDLE:
  - i_start → active <= pending, counters cleared, state RUN next cycle; o_busy rises in that same cycle.
  - i_start with i_cfg_valid in the same cycle → active loads the incoming i_cfg_* values directly (write-through).
  - i_pix_valid or i_out_valid in IDLE → o_overrun set; counters unchanged.
- RUN:
  - o_in_count increments on i_pix_valid; o_out_count increments on i_out_valid. Both may increment in the same cycle.
  - When an accepted i_pix_valid makes in_count == FRAME_PIXELS, go to DRAIN next cycle.
- DRAIN:
  - in_count frozen; further i_pix_valid sets o_overrun.
  - out_count keeps counting.
  - out_count == FRAME_PIXELS → DONE.
  - DRAIN_TIMEOUT cycles elapsed in DRAIN → DONE and o_timeout set.
  - out_count saturates at FRAME_PIXELS; an extra i_out_valid sets o_overrun.
- DONE (exactly 1 cycle): o_frame_done = 1.
  - Next state RUN if i_continuous, with active <= pending and counters cleared.
  - Otherwise next state IDLE; counters hold their final values until the next start.
- i_abort has priority over every transition except reset: next state IDLE, counters cleared, active cfg retained, no o_frame_done, sticky flags unchanged.
- Sticky flags clear only on reset or on i_start accepted from IDLE.
- i_start outside IDLE is ignored.
- All outputs are registered; no combinational path from any input to any output.

Decomposition:
- Package post_proc_pkg:
  - state_t enum: IDLE, RUN, DRAIN, DONE.
  - kernel codes: KERNEL_EDGE = 3'b001 (threshold-eligible), KERNEL_BLUR = 3'b101 (>>4 normalise), KERNEL_EMBOSS = 3'b110 (+128 offset).
  - cfg_t struct: kernel, select_mode, threshold.
- Sub-module frame_counter, instantiated twice (in and out).
  - Ports: clear, enable, freeze; outputs count, at_max.
  - Saturating at FRAME_PIXELS.

Test Plan:
- Reset, write cfg kernel=3'b101 in IDLE → o_cfg_ack next cycle, outputs still 0. i_start → o_kernel_address=5 and o_busy=1 one cycle later.
- IMG 4x2, 8 pix_valid then 8 out_valid (out lagging by 1 cycle) → DRAIN after pixel 8, o_frame_done pulse once, in/out counts = 8, back to IDLE.
- Cfg write kernel=3'b110 during RUN → o_kernel_address unchanged until frame end. With i_continuous=1, second frame shows 6.
- Only 7 of 8 out_valid, DRAIN_TIMEOUT=16 → DONE 16 cycles into DRAIN, o_timeout=1, o_out_count=7.
- 9th pix_valid in DRAIN → o_overrun=1, o_in_count stays 8. Next i_start clears o_overrun.
- i_abort at in_count=3 → IDLE next cycle, counts 0, no o_frame_done, active kernel unchanged.

Source files
------------

// File: rtl/post_proc_pkg.sv
// Shared types for the post-processing frame controller: FSM states,
// kernel codes and the packed configuration word.
package post_proc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] KERNEL_EDGE   = 3'b001;  // threshold-eligible
    localparam logic [2:0] KERNEL_BLUR   = 3'b101;  // >>4 normalise
    localparam logic [2:0] KERNEL_EMBOSS = 3'b110;  // +128 offset

    typedef struct packed {
        logic [2:0] kernel;
        logic       select_mode;
        logic       threshold;
    } cfg_t;

endpackage

// File: rtl/frame_counter.sv
// Saturating per-frame event counter; clear wins over enable, freeze blocks counting.
module frame_counter #(
    parameter int MAX = 307200,
    parameter int W   = 19
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         clear,
    input  logic         enable,
    input  logic         freeze,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] count_reg;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !freeze && !at_max) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count  = count_reg;
    assign at_max = (count_reg == W'(MAX));

endmodule

// File: rtl/post_proc_ctrl.sv
// Frame sequencer for the filter post-processing stage: double-buffered config,
// in/out pixel accounting, drain timeout and sticky error flags.
module post_proc_ctrl
    import post_proc_pkg::*;
#(
    parameter  int IMG_WIDTH     = 640,
    parameter  int IMG_HEIGHT    = 480,
    parameter  int DRAIN_TIMEOUT = 1024,
    localparam int FRAME_PIXELS  = IMG_WIDTH * IMG_HEIGHT,
    localparam int CNT_W         = $clog2(FRAME_PIXELS + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_cfg_valid,
    input  logic [2:0]       i_cfg_kernel,
    input  logic             i_cfg_select_mode,
    input  logic             i_cfg_threshold,
    input  logic             i_start,
    input  logic             i_continuous,
    input  logic             i_abort,
    input  logic             i_pix_valid,
    input  logic             i_out_valid,
    output logic [2:0]       o_kernel_address,
    output logic             o_select_mode,
    output logic             o_threshold,
    output logic             o_cfg_ack,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic [CNT_W-1:0] o_in_count,
    output logic [CNT_W-1:0] o_out_count,
    output logic             o_overrun,
    output logic             o_timeout
);

    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

    state_t     state_reg, state_next;
    cfg_t       pending_reg, active_reg, active_next, cfg_in;
    logic       cfg_ack_reg, busy_reg, done_reg;
    logic       overrun_reg, overrun_next, timeout_reg, timeout_next;
    logic [DW-1:0] drain_reg, drain_next;
    logic       clr_cnt, in_at_max, out_at_max, out_done;
    logic [CNT_W-1:0] in_count, out_count;

    assign cfg_in = '{kernel: i_cfg_kernel, select_mode: i_cfg_select_mode,
                      threshold: i_cfg_threshold};

    frame_counter #(.MAX(FRAME_PIXELS), .W(CNT_W)) u_in_cnt (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .clear(clr_cnt),
        .enable(i_pix_valid), .freeze(state_reg != RUN),
        .count(in_count), .at_max(in_at_max)
    );

    frame_counter #(.MAX(FRAME_PIXELS), .W(CNT_W)) u_out_cnt (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .clear(clr_cnt),
        .enable(i_out_valid), .freeze(!(state_reg == RUN || state_reg == DRAIN)),
        .count(out_count), .at_max(out_at_max)
    );

    // Completion counts the output arriving this cycle, matching the RUN->DRAIN rule.
    assign out_done = out_at_max ||
                      (i_out_valid && out_count == CNT_W'(FRAME_PIXELS - 1));

    always_comb begin
        state_next   = state_reg;
        active_next  = active_reg;
        overrun_next = overrun_reg;
        timeout_next = timeout_reg;
        drain_next   = drain_reg;
        clr_cnt      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (i_start) begin
                    state_next   = RUN;
                    active_next  = i_cfg_valid ? cfg_in : pending_reg;
                    clr_cnt      = 1'b1;
                    overrun_next = 1'b0;
                    timeout_next = 1'b0;
                end else if (i_pix_valid || i_out_valid) begin
                    overrun_next = 1'b1;
                end
            end
            RUN: begin
                if ((i_pix_valid && in_at_max) || (i_out_valid && out_at_max))
                    overrun_next = 1'b1;
                if (i_pix_valid && in_count == CNT_W'(FRAME_PIXELS - 1)) begin
                    state_next = DRAIN;
                    drain_next = '0;
                end
            end
            DRAIN: begin
                drain_next = drain_reg + 1'b1;
                if (i_pix_valid || (i_out_valid && out_at_max))
                    overrun_next = 1'b1;
                if (out_done) begin
                    state_next = DONE;
                end else if (drain_reg == DW'(DRAIN_TIMEOUT - 1)) begin
                    state_next   = DONE;
                    timeout_next = 1'b1;
                end
            end
            DONE: begin
                if (i_continuous) begin
                    state_next  = RUN;
                    active_next = pending_reg;
                    clr_cnt     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort leaves config and sticky flags exactly as they were.
        if (i_abort) begin
            state_next   = IDLE;
            active_next  = active_reg;
            overrun_next = overrun_reg;
            timeout_next = timeout_reg;
            clr_cnt      = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            active_reg  <= '0;
            cfg_ack_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            timeout_reg <= 1'b0;
            drain_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            active_reg  <= active_next;
            cfg_ack_reg <= i_cfg_valid;
            busy_reg    <= (state_next != IDLE);
            done_reg    <= (state_next == DONE);
            overrun_reg <= overrun_next;
            timeout_reg <= timeout_next;
            drain_reg   <= drain_next;
            if (i_cfg_valid)
                pending_reg <= cfg_in;
        end
    end

    assign o_kernel_address = active_reg.kernel;
    assign o_select_mode    = active_reg.select_mode;
    assign o_threshold      = active_reg.threshold;
    assign o_cfg_ack        = cfg_ack_reg;
    assign o_busy           = busy_reg;
    assign o_frame_done     = done_reg;
    assign o_in_count       = in_count;
    assign o_out_count      = out_count;
    assign o_overrun        = overrun_reg;
    assign o_timeout        = timeout_reg;

endmodule

// File: tb/tb_post_proc_ctrl.sv
// Directed bench for post_proc_ctrl on a 4x2 frame with a 16-cycle drain timeout.
module tb_post_proc_ctrl;

    localparam int W = 4;
    localparam int H = 2;
    localparam int DT = 16;
    localparam int CNT_W = $clog2(W * H + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_valid = 1'b0;
    logic [2:0] cfg_kernel = '0;
    logic cfg_sel = 1'b0;
    logic cfg_thr = 1'b0;
    logic start = 1'b0;
    logic continuous = 1'b0;
    logic abort = 1'b0;
    logic pix_valid = 1'b0;
    logic out_valid = 1'b0;
    logic [2:0] kernel_address;
    logic select_mode, threshold, cfg_ack, busy, frame_done, overrun, timeout;
    logic [CNT_W-1:0] in_count, out_count;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done) done_pulses++;

    post_proc_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DRAIN_TIMEOUT(DT)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_cfg_valid(cfg_valid), .i_cfg_kernel(cfg_kernel),
        .i_cfg_select_mode(cfg_sel), .i_cfg_threshold(cfg_thr),
        .i_start(start), .i_continuous(continuous), .i_abort(abort),
        .i_pix_valid(pix_valid), .i_out_valid(out_valid),
        .o_kernel_address(kernel_address), .o_select_mode(select_mode),
        .o_threshold(threshold), .o_cfg_ack(cfg_ack), .o_busy(busy),
        .o_frame_done(frame_done), .o_in_count(in_count), .o_out_count(out_count),
        .o_overrun(overrun), .o_timeout(timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_kernel", 32'(kernel_address), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt", 32'({in_count, out_count}), 0);
        check("rst_flags", 32'({cfg_ack, frame_done, overrun, timeout}), 0);
        rst_n = 1'b1;
        step();

        // Config write in IDLE: ack next cycle, active untouched
        cfg_valid = 1'b1; cfg_kernel = 3'b101; cfg_sel = 1'b1; cfg_thr = 1'b0;
        step();
        cfg_valid = 1'b0;
        check("cfg_ack", 32'(cfg_ack), 1);
        check("cfg_kernel_idle", 32'(kernel_address), 0);
        check("cfg_busy_idle", 32'(busy), 0);
        step();
        check("cfg_ack_pulse", 32'(cfg_ack), 0);

        // Frame 1: start, 8 pixels, outputs lagging by one cycle
        start = 1'b1;
        step();
        start = 1'b0;
        check("f1_kernel", 32'(kernel_address), 5);
        check("f1_sel", 32'(select_mode), 1);
        check("f1_busy", 32'(busy), 1);
        for (int i = 0; i <= 8; i++) begin
            pix_valid = (i < 8);
            out_valid = (i >= 1);
            step();
            if (i == 7) begin
                check("f1_in_full", 32'(in_count), 8);
                check("f1_out_lag", 32'(out_count), 7);
                check("f1_no_done_yet", 32'(frame_done), 0);
            end
            if (i == 8) begin
                check("f1_done", 32'(frame_done), 1);
                check("f1_out_full", 32'(out_count), 8);
            end
        end
        pix_valid = 1'b0; out_valid = 1'b0;
        step();
        check("f1_done_clear", 32'(frame_done), 0);
        check("f1_idle_busy", 32'(busy), 0);
        check("f1_hold_in", 32'(in_count), 8);
        check("f1_hold_out", 32'(out_count), 8);
        check("f1_pulses", done_pulses, 1);

        // Frame 2: continuous, config written mid-frame stays pending
        continuous = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("f2_cnt_clear", 32'({in_count, out_count}), 0);
        for (int i = 0; i <= 8; i++) begin
            pix_valid = (i < 8);
            out_valid = (i >= 1);
            cfg_valid = (i == 2);
            if (i == 2) begin
                cfg_kernel = 3'b110; cfg_sel = 1'b0; cfg_thr = 1'b1;
            end
            step();
            if (i == 4) check("f2_kernel_mid", 32'(kernel_address), 5);
            if (i == 8) begin
                check("f2_done", 32'(frame_done), 1);
                check("f2_kernel_done", 32'(kernel_address), 5);
            end
        end
        pix_valid = 1'b0; out_valid = 1'b0; cfg_valid = 1'b0;
        step();
        continuous = 1'b0;
        check("f3_kernel", 32'(kernel_address), 6);
        check("f3_cfg_bits", 32'({select_mode, threshold}), 1);
        check("f3_busy", 32'(busy), 1);
        check("f3_cnt_clear", 32'({in_count, out_count}), 0);

        // Frame 3: only 7 outputs, 9th pixel in DRAIN, drain timeout
        for (int i = 0; i <= 23; i++) begin
            pix_valid = (i <= 8);
            out_valid = (i >= 1 && i <= 7);
            step();
            if (i == 8) begin
                check("f3_overrun", 32'(overrun), 1);
                check("f3_in_frozen", 32'(in_count), 8);
            end
            if (i == 22) begin
                check("f3_no_done_early", 32'(frame_done), 0);
                check("f3_no_tmo_early", 32'(timeout), 0);
            end
            if (i == 23) begin
                check("f3_done", 32'(frame_done), 1);
                check("f3_timeout", 32'(timeout), 1);
                check("f3_out", 32'(out_count), 7);
                check("f3_in", 32'(in_count), 8);
            end
        end
        pix_valid = 1'b0; out_valid = 1'b0;
        step();
        check("f3_idle_busy", 32'(busy), 0);
        check("f3_pulses", done_pulses, 3);
        check("f3_flags_hold", 32'({overrun, timeout}), 3);

        // New start clears sticky flags
        start = 1'b1;
        step();
        start = 1'b0;
        check("f4_flags_clear", 32'({overrun, timeout}), 0);
        check("f4_kernel", 32'(kernel_address), 6);

        // Abort at in_count = 3
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1;
            step();
        end
        pix_valid = 1'b0;
        check("ab_in3", 32'(in_count), 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_busy", 32'(busy), 0);
        check("ab_cnt", 32'({in_count, out_count}), 0);
        check("ab_kernel", 32'(kernel_address), 6);
        repeat (3) step();
        check("ab_no_done", done_pulses, 3);
        check("ab_flags", 32'({overrun, timeout}), 0);

        // Pixel in IDLE flags overrun without counting
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        check("idle_overrun", 32'(overrun), 1);
        check("idle_in", 32'(in_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
